// File: rtl/halt_detector.sv
// halt_detector: watches the retired-instruction stream and raises a sticky
// `ended` when the CPU settles into a terminal tight loop (period 1 or 2)
// or when the retired-instruction budget runs out. Pure observer.
module halt_detector #(
   parameter int unsigned PC_WIDTH  = 15,
   parameter int unsigned CONFIRM   = 4,
   parameter int unsigned MAX_STEPS = 100000,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 mem_write,
   output logic                 ended,
   output logic                 timeout,
   output logic [PC_WIDTH-1:0]  halt_pc,
   output logic [CNT_WIDTH-1:0] step_count
);

   localparam int unsigned STREAK_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTED  = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_e;

   state_e                state_q,      state_d;
   logic [PC_WIDTH-1:0]   prev_pc_q,    prev_pc_d;
   logic [PC_WIDTH-1:0]   prev2_pc_q,   prev2_pc_d;
   logic [1:0]            hist_q,       hist_d;
   logic [STREAK_W-1:0]   streak_q,     streak_d;
   logic [CNT_WIDTH-1:0]  step_count_q, step_count_d;
   logic                  ended_q,      ended_d;
   logic                  timeout_q,    timeout_d;
   logic [PC_WIDTH-1:0]   halt_pc_q,    halt_pc_d;

   logic                  hit_p1_c;
   logic                  hit_p2_c;
   logic                  hit_c;
   logic [CNT_WIDTH:0]    cnt_inc_c;

   // Loop-hit detection against the retained history.
   always_comb begin
      hit_p1_c  = (hist_q != 2'd0) && (pc == prev_pc_q);
      hit_p2_c  = (hist_q == 2'd2) && (pc == prev2_pc_q);
      hit_c     = (hit_p1_c || hit_p2_c) && !mem_write;
      cnt_inc_c = {1'b0, step_count_q} + (CNT_WIDTH + 1)'(1);
   end

   // Next-state: history, streak, counter and halt/timeout decision.
   always_comb begin
      state_d      = state_q;
      prev_pc_d    = prev_pc_q;
      prev2_pc_d   = prev2_pc_q;
      hist_d       = hist_q;
      streak_d     = streak_q;
      step_count_d = step_count_q;
      ended_d      = ended_q;
      timeout_d    = timeout_q;
      halt_pc_d    = halt_pc_q;

      if (state_q == ST_RUN && step) begin
         prev2_pc_d = prev_pc_q;
         prev_pc_d  = pc;
         hist_d     = (hist_q == 2'd2) ? 2'd2 : hist_q + 2'd1;

         if (!hit_c)
            streak_d = '0;
         else if (streak_q != STREAK_W'(CONFIRM))
            streak_d = streak_q + STREAK_W'(1);

         if (step_count_q != {CNT_WIDTH{1'b1}})
            step_count_d = step_count_q + CNT_WIDTH'(1);

         // Halt takes priority over a coincident budget expiry.
         if (hit_c && streak_q == STREAK_W'(CONFIRM - 1)) begin
            state_d = ST_HALTED;
            ended_d = 1'b1;
            if (hit_p1_c)
               halt_pc_d = pc;
            else
               halt_pc_d = (pc < prev_pc_q) ? pc : prev_pc_q;
         end else if (cnt_inc_c == (CNT_WIDTH + 1)'(MAX_STEPS)) begin
            state_d   = ST_TIMEOUT;
            ended_d   = 1'b1;
            timeout_d = 1'b1;
            halt_pc_d = pc;
         end
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         prev_pc_q    <= '0;
         prev2_pc_q   <= '0;
         hist_q       <= 2'd0;
         streak_q     <= '0;
         step_count_q <= '0;
         ended_q      <= 1'b0;
         timeout_q    <= 1'b0;
         halt_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         prev_pc_q    <= prev_pc_d;
         prev2_pc_q   <= prev2_pc_d;
         hist_q       <= hist_d;
         streak_q     <= streak_d;
         step_count_q <= step_count_d;
         ended_q      <= ended_d;
         timeout_q    <= timeout_d;
         halt_pc_q    <= halt_pc_d;
      end
   end

   assign ended      = ended_q;
   assign timeout    = timeout_q;
   assign halt_pc    = halt_pc_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_halt_detector.sv
// Directed bench for halt_detector: four instances with different budgets
// share one retire stream; expected values are hand-computed constants.
module tb_halt_detector;

   logic        clk;
   logic        reset;
   logic        step;
   logic [14:0] pc;
   logic        mem_write;

   // 0: default budget, 1: MAX_STEPS=20, 2: MAX_STEPS=8, 3: MAX_STEPS=10
   logic        ended      [4];
   logic        timeout    [4];
   logic [14:0] halt_pc    [4];
   logic [31:0] step_count [4];

   int checks;
   int errors;

   halt_detector #(.PC_WIDTH(15), .CONFIRM(4), .MAX_STEPS(100000), .CNT_WIDTH(32)) u_dut_a (
      .clk(clk), .reset(reset), .step(step), .pc(pc), .mem_write(mem_write),
      .ended(ended[0]), .timeout(timeout[0]), .halt_pc(halt_pc[0]), .step_count(step_count[0]));
   halt_detector #(.PC_WIDTH(15), .CONFIRM(4), .MAX_STEPS(20), .CNT_WIDTH(32)) u_dut_b (
      .clk(clk), .reset(reset), .step(step), .pc(pc), .mem_write(mem_write),
      .ended(ended[1]), .timeout(timeout[1]), .halt_pc(halt_pc[1]), .step_count(step_count[1]));
   halt_detector #(.PC_WIDTH(15), .CONFIRM(4), .MAX_STEPS(8), .CNT_WIDTH(32)) u_dut_c (
      .clk(clk), .reset(reset), .step(step), .pc(pc), .mem_write(mem_write),
      .ended(ended[2]), .timeout(timeout[2]), .halt_pc(halt_pc[2]), .step_count(step_count[2]));
   halt_detector #(.PC_WIDTH(15), .CONFIRM(4), .MAX_STEPS(10), .CNT_WIDTH(32)) u_dut_d (
      .clk(clk), .reset(reset), .step(step), .pc(pc), .mem_write(mem_write),
      .ended(ended[3]), .timeout(timeout[3]), .halt_pc(halt_pc[3]), .step_count(step_count[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One retire: drive at negedge, sample 1 ns after the capturing posedge.
   task automatic retire(input int unsigned p, input logic mw);
      @(negedge clk);
      step      = 1'b1;
      pc        = 15'(p);
      mem_write = mw;
      @(posedge clk);
      #1;
      step      = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse, checked before any clock edge can occur.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) begin
         check({tag, "_ended"},   32'(ended[d]),   32'd0);
         check({tag, "_timeout"}, 32'(timeout[d]), 32'd0);
         check({tag, "_halt_pc"}, 32'(halt_pc[d]), 32'd0);
         check({tag, "_count"},   step_count[d],   32'd0);
      end
      #1;
      reset = 1'b0;
   endtask

   int unsigned seq1 [10];

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      step      = 1'b0;
      pc        = '0;
      mem_write = 1'b0;
      seq1      = '{0, 1, 2, 3, 10, 11, 10, 11, 10, 11};

      #2;
      check("rst_ended",   32'(ended[0]),   32'd0);
      check("rst_timeout", 32'(timeout[0]), 32'd0);
      check("rst_count",   step_count[0],   32'd0);
      #20;
      reset = 1'b0;

      // Period-2 loop, back-to-back retires.
      for (int i = 0; i < 10; i++) begin
         retire(seq1[i], 1'b0);
         check("s1_ended", 32'(ended[0]), 32'(i == 9));
      end
      check("s1_halt_pc", 32'(halt_pc[0]), 32'd10);
      check("s1_count",   step_count[0],   32'd10);
      check("s1_timeout", 32'(timeout[0]), 32'd0);
      // Halt and budget coincide on the 10th retire: halt wins.
      check("s1_tie_ended",   32'(ended[3]),   32'd1);
      check("s1_tie_timeout", 32'(timeout[3]), 32'd0);
      check("s1_tie_halt_pc", 32'(halt_pc[3]), 32'd10);
      // Budget of 8 expires first on pc 11.
      check("s1_c_timeout", 32'(timeout[2]), 32'd1);
      check("s1_c_halt_pc", 32'(halt_pc[2]), 32'd11);
      check("s1_c_count",   step_count[2],   32'd8);
      do_reset("r1");

      // Same sequence with idle cycles between retires.
      for (int i = 0; i < 10; i++) begin
         retire(seq1[i], 1'b0);
         check("s2_ended", 32'(ended[0]), 32'(i == 9));
         idle();
         check("s2_ended_idle", 32'(ended[0]), 32'(i == 9));
         check("s2_count_idle", step_count[0], 32'(i + 1));
      end
      check("s2_halt_pc", 32'(halt_pc[0]), 32'd10);
      check("s2_timeout", 32'(timeout[0]), 32'd0);
      do_reset("r2");

      // Period-1 loop.
      for (int i = 0; i < 5; i++) begin
         retire(5, 1'b0);
         check("s3_ended", 32'(ended[0]), 32'(i == 4));
      end
      check("s3_halt_pc", 32'(halt_pc[0]), 32'd5);
      check("s3_count",   step_count[0],   32'd5);
      do_reset("r3");

      // Loop that writes memory never halts; budget 20 expires.
      for (int i = 0; i < 20; i++) begin
         retire((i % 2 == 0) ? 10 : 11, logic'(i % 2 == 1));
         check("s4_ended", 32'(ended[1]), 32'(i == 19));
      end
      check("s4_timeout",  32'(timeout[1]), 32'd1);
      check("s4_halt_pc",  32'(halt_pc[1]), 32'd11);
      check("s4_count",    step_count[1],   32'd20);
      check("s4_no_halt",  32'(ended[0]),   32'd0);
      check("s4_a_count",  step_count[0],   32'd20);
      do_reset("r4");

      // Straight-line code, budget 8; outputs frozen afterwards.
      for (int i = 0; i < 10; i++) begin
         retire(i, 1'b0);
         check("s5_ended",   32'(ended[2]),  32'(i >= 7));
         check("s5_timeout", 32'(timeout[2]), 32'(i >= 7));
         check("s5_count",   step_count[2],  32'((i >= 7) ? 8 : i + 1));
      end
      check("s5_halt_pc", 32'(halt_pc[2]), 32'd7);
      do_reset("r5");

      // Reset mid-run, then replay cleanly.
      for (int i = 0; i < 8; i++) retire(seq1[i], 1'b0);
      check("s6_count_pre", step_count[0], 32'd8);
      do_reset("r6");
      for (int i = 0; i < 10; i++) begin
         retire(seq1[i], 1'b0);
         check("s6_ended", 32'(ended[0]), 32'(i == 9));
      end
      check("s6_halt_pc", 32'(halt_pc[0]), 32'd10);
      check("s6_count",   step_count[0],   32'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/halt_detector.md
# halt_detector

Produces the `ended` signal that simulation benches and the board top-level consume from the computer. It watches the CPU's retired-instruction stream (PC, memory-write strobe) and declares the program finished when execution settles into the terminal tight-loop idiom, `(END) @END; 0;JMP`, or when a hard cycle budget expires. It sits beside the CPU inside the computer top and is purely an observer; it never stalls or modifies execution.

## Interface
- `PC_WIDTH`, 15: width of the program counter.
- `CONFIRM`, 4: consecutive loop hits required to declare halt (≥1).
- `MAX_STEPS`, 100000: retired-instruction budget before timeout (≥1).
- `CNT_WIDTH`, 32: width of the step counter.

- `clk`  in  1  clock. One clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `step`  in  1  high when an instruction retires this cycle; `pc`/`mem_write` are valid only then.
- `pc`  in  PC_WIDTH  address of the retiring instruction.
- `mem_write`  in  1  retiring instruction writes data memory (writeM).
- `ended`  out  1  program finished (halt or timeout); sticky until reset.
- `timeout`  out  1  finish was caused by budget expiry.
- `halt_pc`  out  PC_WIDTH  lower address of the detected terminal loop.
- `step_count`  out  CNT_WIDTH  retired instructions counted while RUN, frozen at finish.

## Operation
- States: RUN (after reset), HALTED, TIMEOUT. HALTED and TIMEOUT are terminal; they exit only via reset.
- Registered history: `prev_pc`, `prev2_pc`, and `hist` (0..2 valid entries, saturating), updated only on `step` in RUN.
- Loop hit, evaluated on a `step` edge in RUN: (`hist`≥1 and `pc`==`prev_pc`) or (`hist`==2 and `pc`==`prev2_pc`), and `mem_write`==0.
- `streak`: on a `step` edge, hit → `streak`+1 (saturating at CONFIRM); miss → 0. Held when `step`=0.
- Halt: on a `step` edge in RUN with hit and `streak`==CONFIRM−1 → HALTED, `ended`←1, `halt_pc`←min(`pc`,`prev_pc`) for the period-2 case and `pc` for the period-1 case.
- `step_count`: +1 on every `step` edge in RUN, including the terminating one; saturates at all-ones.
- Timeout: on a `step` edge in RUN where `step_count`+1 == MAX_STEPS and no halt → TIMEOUT, `ended`←1, `timeout`←1, `halt_pc`←`pc`.
- Simultaneous halt and timeout on the same edge: halt wins, `timeout`=0.
- Any write inside a loop breaks the streak, so a spin loop that polls and writes memory is not a halt.

## Timing
- Reset values (asynchronous, immediate): `ended`=0, `timeout`=0, `halt_pc`=0, `step_count`=0, `streak`=0, `hist`=0, state RUN.
- All outputs are registered. `ended` rises one clock edge after the terminating retire is sampled, in the same cycle that `step_count` shows its final value.
- Minimum detection latency: 2+CONFIRM retires for a period-2 loop, 1+CONFIRM for a period-1 loop.
- `step`=0 cycles are invisible: no history, streak, or count change.
- Reset asserted mid-run or after finish clears everything asynchronously. Detection restarts cleanly after deassertion, and the first post-reset retire is not compared against stale history.

## Test plan
- PC 0,1,2,3,10,11,10,11,10,11 with `step`=1 and CONFIRM=4 → `ended` rises after the 10th retire; `halt_pc`=10, `step_count`=10, `timeout`=0.
- Same sequence with `step` low on every other cycle → identical final outputs; `ended` rises after the 10th `step` edge.
- PC 5,5,5,5,5 (period 1) with CONFIRM=4 → `ended` after the 5th retire; `halt_pc`=5, `step_count`=5.
- Loop 10,11 repeated with `mem_write`=1 on each 11 and MAX_STEPS=20 → no halt; `ended`=1 and `timeout`=1 after the 20th retire; `step_count`=20, `halt_pc`=11.
- Increasing PC 0..9 with MAX_STEPS=8 → TIMEOUT after the 8th retire; `halt_pc`=7, `step_count`=8. Further steps leave all outputs unchanged.
- Assert `reset` asynchronously after the 8th retire of the first scenario → all outputs 0 immediately. Replaying the first scenario reproduces `ended` after the 10th retire.
